branch_resolve_queue: RTL and testbench

- In-order queue of in-flight conditional-branch predictions. The fetch stage writes an entry for each branch at prediction time; the EX stage reads the oldest entry at resolution.
- Compares the prediction with the actual outcome. Drives a one-cycle training pulse (PC, outcome) to the global-history predictor.
- On a mispredict, drives the fetch redirect, a global-history restore value and a flush of all younger queue entries.

---
 rtl/branch_resolve_queue.sv | 121 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Resolves the oldest entry,
// trains the predictor, and redirects fetch and restores history on a mispredict.
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int GHR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  logic [31:0]      push_pc,
   input  logic             push_pred_taken,
   input  logic [31:0]      push_pred_target,
   input  logic [GHR_W-1:0] push_ghr,
   output logic             full,
   input  logic             resolve_valid,
   input  logic             resolve_taken,
   input  logic [31:0]      resolve_target,
   output logic             upd_en,
   output logic             upd_taken,
   output logic [31:0]      upd_pc,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic             ghr_restore_en,
   output logic [GHR_W-1:0] ghr_restore,
   output logic [PTR_W:0]   count,
   output logic             resolve_err
);

   typedef struct packed {
      logic [31:0]      pc;
      logic             pred_taken;
      logic [31:0]      pred_target;
      logic [GHR_W-1:0] ghr;
   } entry_t;

   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   entry_t           head;
   logic             empty;
   logic             do_resolve;
   logic             mis;
   logic             push_accept;
   logic [31:0]      correct_pc;
   logic [GHR_W-1:0] restored;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_CNT);
   assign head  = mem[rd_ptr];

   always_comb begin
      do_resolve = resolve_valid && !empty;
      mis        = (head.pred_taken != resolve_taken) ||
                   (head.pred_taken && resolve_taken && (head.pred_target != resolve_target));
      correct_pc = resolve_taken ? resolve_target : head.pc + 32'd4;
      restored   = {head.ghr[GHR_W-2:0], resolve_taken};
      // A pop in the same cycle frees a slot, so full only blocks a lone push;
      // a push alongside a mispredict is wrong-path and discarded.
      push_accept = push_valid && (!full || do_resolve) && !(do_resolve && mis);
   end

   // NOTE: the entry storage carries no reset; count/pointers alone define which
   // slots are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push_accept)
         mem[wr_ptr] <= '{pc: push_pc, pred_taken: push_pred_taken,
                          pred_target: push_pred_target, ghr: push_ghr};
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         upd_en         <= 1'b0;
         upd_taken      <= 1'b0;
         upd_pc         <= '0;
         mispredict     <= 1'b0;
         redirect_pc    <= '0;
         ghr_restore_en <= 1'b0;
         ghr_restore    <= '0;
         resolve_err    <= 1'b0;
      end else begin
         upd_en         <= 1'b0;
         mispredict     <= 1'b0;
         ghr_restore_en <= 1'b0;

         if (resolve_valid && empty)
            resolve_err <= 1'b1;

         if (do_resolve) begin
            upd_en    <= 1'b1;
            upd_taken <= resolve_taken;
            upd_pc    <= head.pc;
            rd_ptr    <= rd_ptr + PTR_ONE;
            if (mis) begin
               mispredict     <= 1'b1;
               redirect_pc    <= correct_pc;
               ghr_restore_en <= 1'b1;
               ghr_restore    <= restored;
               wr_ptr         <= rd_ptr + PTR_ONE;
               count          <= '0;
            end else if (push_accept) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end else begin
               count <= count - CNT_ONE;
            end
         end else if (push_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a behavioural queue model produces
// expected training/redirect results, compared one cycle after each resolve.
module tb_branch_resolve_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   localparam int GHR_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             push_valid;
   logic [31:0]      push_pc;
   logic             push_pred_taken;
   logic [31:0]      push_pred_target;
   logic [GHR_W-1:0] push_ghr;
   logic             full;
   logic             resolve_valid;
   logic             resolve_taken;
   logic [31:0]      resolve_target;
   logic             upd_en;
   logic             upd_taken;
   logic [31:0]      upd_pc;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic             ghr_restore_en;
   logic [GHR_W-1:0] ghr_restore;
   logic [PTR_W:0]   count;
   logic             resolve_err;

   branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .GHR_W(GHR_W)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
      .push_pred_target(push_pred_target), .push_ghr(push_ghr), .full(full),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target), .upd_en(upd_en), .upd_taken(upd_taken),
      .upd_pc(upd_pc), .mispredict(mispredict), .redirect_pc(redirect_pc),
      .ghr_restore_en(ghr_restore_en), .ghr_restore(ghr_restore),
      .count(count), .resolve_err(resolve_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      pc;
      logic             pt;
      logic [31:0]      tgt;
      logic [GHR_W-1:0] ghr;
   } ent_t;

   typedef struct {
      logic             taken;
      logic [31:0]      pc;
      logic             mis;
      logic [31:0]      redirect;
      logic [GHR_W-1:0] ghr;
   } exp_t;

   ent_t             m_q[$];
   exp_t             exp_q[$];
   logic             m_err;
   logic [31:0]      h_upd_pc, h_redirect;
   logic [GHR_W-1:0] h_ghr;
   int               n_checks = 0;
   int               n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_err      = 1'b0;
      h_upd_pc   = '0;
      h_redirect = '0;
      h_ghr      = '0;
   endtask

   // Drive one cycle of stimulus, advance the model, clock, then compare.
   task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                       input logic [31:0] tgt, input logic [GHR_W-1:0] g,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
      logic resolving, mis;
      ent_t e;
      exp_t x;
      push_valid = pv; push_pc = pc; push_pred_taken = pt;
      push_pred_target = tgt; push_ghr = g;
      resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;

      resolving = rv && (m_q.size() != 0);
      mis = 1'b0;
      if (rv && !resolving) m_err = 1'b1;
      if (resolving) begin
         e   = m_q.pop_front();
         mis = (e.pt != rt) || (e.pt && rt && (e.tgt != rtgt));
         x.taken    = rt;
         x.pc       = e.pc;
         x.mis      = mis;
         x.redirect = rt ? rtgt : e.pc + 32'd4;
         x.ghr      = {e.ghr[GHR_W-2:0], rt};
         exp_q.push_back(x);
      end
      if (pv && !mis && m_q.size() < DEPTH)
         m_q.push_back('{pc: pc, pt: pt, tgt: tgt, ghr: g});
      if (mis) m_q.delete();

      @(posedge clk);
      #1;
      check("upd_en", upd_en, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         x = exp_q.pop_front();
         check("upd_taken", upd_taken, x.taken);
         check("mispredict", mispredict, x.mis);
         check("ghr_restore_en", ghr_restore_en, x.mis);
         h_upd_pc = x.pc;
         if (x.mis) begin
            h_redirect = x.redirect;
            h_ghr      = x.ghr;
         end
      end else begin
         check("mispredict_idle", mispredict, 1'b0);
         check("ghr_restore_en_idle", ghr_restore_en, 1'b0);
      end
      check("upd_pc", upd_pc, h_upd_pc);
      check("redirect_pc", redirect_pc, h_redirect);
      check("ghr_restore", ghr_restore, h_ghr);
      check("count", count, m_q.size());
      check("full", full, m_q.size() == DEPTH);
      check("resolve_err", resolve_err, m_err);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check("rst_count", count, 0);
      check("rst_upd_en", upd_en, 0);
      check("rst_mispredict", mispredict, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_err", resolve_err, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      push_valid = 0; push_pc = 0; push_pred_taken = 0; push_pred_target = 0; push_ghr = 0;
      resolve_valid = 0; resolve_taken = 0; resolve_target = 0;
      #2;
      do_reset();

      // Correct not-taken prediction.
      step(1, 32'h100, 0, 0, 8'h00, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      idle();

      // Not-taken predicted, taken actual: history 0x5A restores to 0xB5.
      step(1, 32'h200, 0, 0, 8'h5A, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 32'h300);
      check("redirect_300", redirect_pc, 32'h300);
      check("restore_b5", ghr_restore, 8'hB5);
      idle();

      // Fill, drop a fifth push, then mispredict the second entry.
      for (int i = 1; i <= 4; i++)
         step(1, 32'h10 * i, 1, 32'h1000 + 32'h10 * i, 8'(i), 0, 0, 0);
      check("full_after_4", full, 1);
      step(1, 32'h50, 1, 32'h1050, 8'h05, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 32'h1010);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      check("redirect_24", redirect_pc, 32'h24);
      idle();

      // Full queue with push+correct resolve each cycle; pointers wrap.
      for (int i = 0; i < 4; i++)
         step(1, 32'h400 + 32'h10 * i, 1, 32'h2000 + i, 8'(i), 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(1, 32'h440 + 32'h10 * i, 0, 0, 8'h30 + 8'(i), 1, 1, 32'h2000 + i);
      check("count_stays_4", count, 4);
      step(0, 0, 0, 0, 0, 1, 1, 32'h2003);
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 0, 1, 0, 0);
      idle();

      // Taken with wrong target.
      step(1, 32'h480, 1, 32'h500, 8'hC3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 32'h504);
      check("redirect_504", redirect_pc, 32'h504);
      idle();

      // Resolve while empty sets the sticky error.
      step(0, 0, 0, 0, 0, 1, 1, 32'h999);
      idle();

      // Asynchronous reset mid-stream with a pending resolve.
      for (int i = 0; i < 3; i++)
         step(1, 32'h600 + 32'h10 * i, 0, 0, 8'h11, 0, 0, 0);
      check("pre_rst_count", count, 3);
      resolve_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("async_count", count, 0);
      check("async_err", resolve_err, 0);
      check("async_full", full, 0);
      model_reset();
      @(posedge clk);
      #1;
      check("no_pulse_in_rst", upd_en, 0);
      rst = 1'b0;
      idle();
      step(1, 32'h700, 0, 0, 8'h01, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
